// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared types and sizing for the sliced 64-bit add/sub arbiter
package add_pkg;

  localparam int SLICE_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int n_slices(input int slice_w);
    return 64 / slice_w;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// rtl/cla_slice.sv - combinational W-bit carry-lookahead adder slice
module cla_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] g;
  logic [W-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is group-generate | group-propagate & cin, so cin never ripples.
  always_comb begin
    logic gacc;
    logic pacc;
    gacc = 1'b0;
    pacc = 1'b1;
    sum  = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = p[i] ^ (gacc | (pacc & cin));
      gacc   = g[i] | (p[i] & gacc);
      pacc   = p[i] & pacc;
    end
    cout = gacc | (pacc & cin);
  end

endmodule

// File: rtl/add64_seq_arb.sv
// rtl/add64_seq_arb.sv - two-requester arbiter feeding a slice-serial 64-bit adder/subtractor
module add64_seq_arb
  import add_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic        req1_sub,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_sum,
  output logic        resp_cout,
  output logic        resp_ovf,
  output logic        resp_id
);

  localparam int N_SLICES = n_slices(SLICE_W);
  localparam int IDX_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

  state_t             state;
  state_t             next_state;
  logic [63:0]        op_a;
  logic [63:0]        op_b;
  logic [63:0]        result;
  logic               carry;
  logic               last_id;
  logic               cur_id;
  logic               cout_q;
  logic               ovf_q;
  logic [IDX_W-1:0]   idx;

  logic               grant;
  logic               accept;
  logic               last_slice;
  logic [63:0]        sel_a;
  logic [63:0]        sel_b;
  logic               sel_sub;
  logic [SLICE_W-1:0] s_a;
  logic [SLICE_W-1:0] s_b;
  logic [SLICE_W-1:0] s_sum;
  logic               s_cout;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant      = (req0_valid & req1_valid) ? ~last_id : req1_valid;
    req0_ready = rst_n & (state == IDLE) & req0_valid & ~grant;
    req1_ready = rst_n & (state == IDLE) & req1_valid & grant;
    accept     = req0_ready | req1_ready;
    sel_a      = req1_ready ? req1_a   : req0_a;
    sel_b      = req1_ready ? req1_b   : req0_b;
    sel_sub    = req1_ready ? req1_sub : req0_sub;
    s_a        = op_a[idx*SLICE_W +: SLICE_W];
    s_b        = op_b[idx*SLICE_W +: SLICE_W];
    last_slice = (idx == IDX_W'(N_SLICES - 1));
  end

  cla_slice #(.W(SLICE_W)) u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)     next_state = RUN;
      RUN:     if (last_slice) next_state = DONE;
      DONE:    if (resp_ready) next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      result  <= '0;
      carry   <= 1'b0;
      last_id <= 1'b1;
      cur_id  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a    <= sel_a;
            op_b    <= sel_sub ? ~sel_b : sel_b;
            carry   <= sel_sub;
            cur_id  <= req1_ready;
            last_id <= req1_ready;
            idx     <= '0;
          end
        end
        RUN: begin
          result[idx*SLICE_W +: SLICE_W] <= s_sum;
          carry <= s_cout;
          idx   <= idx + IDX_W'(1);
          if (last_slice) begin
            cout_q <= s_cout;
            ovf_q  <= (op_a[63] == op_b[63]) & (s_sum[SLICE_W-1] != op_a[63]);
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (state == DONE);
  assign resp_sum   = result;
  assign resp_cout  = cout_q;
  assign resp_ovf   = ovf_q;
  assign resp_id    = cur_id;

endmodule
